// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pkg
//  Description : Shared defaults and width helpers for the vector MAC pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    localparam int c_def_n_lanes   = 5;
    localparam int c_def_dw        = 8;
    localparam int c_def_out_w     = 16;
    localparam int c_def_max_beats = 16;

    // Accumulator width large enough that a full-length vector of worst-case
    // products can never wrap: product (2*DW+1, signed) plus growth from the
    // lane reduction and from summing up to max_beats beats.
    function automatic int acc_width(input int dw, input int n_lanes, input int max_beats);
        return 2 * dw + 1 + $clog2(n_lanes) + $clog2(max_beats);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_add_tree.sv
`default_nettype none
// ============================================================================
//  Module      : mac_add_tree
//  Description : Registered signed reduction of N_LANES packed operands.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                en           - load enable for the output register
//                in_data      - N_LANES signed values, lane i at [i*IN_W +: IN_W]
//                sum_out      - registered signed sum, SUM_W bits
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_add_tree
    import mac_pkg::*;
#(
    parameter int N_LANES = c_def_n_lanes,
    parameter int IN_W    = 17,
    parameter int SUM_W   = IN_W + $clog2(N_LANES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_LANES*IN_W-1:0]  in_data,
    output logic [SUM_W-1:0]         sum_out
);

    logic [SUM_W-1:0] w_sum;

    // Each lane is sign-extended to the full sum width before adding, so the
    // result is exact for any mix of signs.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N_LANES; i++) begin
            w_sum = w_sum + SUM_W'($signed(in_data[i*IN_W +: IN_W]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_out <= '0;
        end else if (en) begin
            sum_out <= w_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_vec_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mac_vec_pipe
//  Description : Three-stage vector dot-product pipeline with saturation.
//                S1 registers per-lane products, S2 registers the lane sum,
//                S3 accumulates beats and emits the clamped vector result.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                a_in, c_in            - packed attributes / coefficients
//                in_signed             - operand mode, sampled on first beat
//                in_last               - final beat of the vector
//                in_valid / in_ready   - input handshake
//                out_data              - saturated dot product
//                out_sat / out_err     - clamped / force-terminated flags
//                out_valid / out_ready - output handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_vec_pipe
    import mac_pkg::*;
#(
    parameter int N_LANES   = c_def_n_lanes,
    parameter int DW        = c_def_dw,
    parameter int OUT_W     = c_def_out_w,
    parameter int MAX_BEATS = c_def_max_beats
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_LANES*DW-1:0]   a_in,
    input  logic [N_LANES*DW-1:0]   c_in,
    input  logic                    in_signed,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_sat,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int c_prod_w = 2 * DW + 1;
    localparam int c_sum_w  = c_prod_w + $clog2(N_LANES);
    localparam int c_acc_w  = acc_width(DW, N_LANES, MAX_BEATS);
    localparam int c_cnt_w  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    // Clamp bounds expressed at accumulator width.
    localparam logic signed [c_acc_w-1:0] c_smax =
        {{(c_acc_w-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [c_acc_w-1:0] c_smin =
        {{(c_acc_w-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [c_acc_w-1:0] c_umax =
        {{(c_acc_w-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    // ------------------------------------------------------------------
    // Handshake and beat tracking
    // ------------------------------------------------------------------
    logic                 w_stall;
    logic                 w_accept;
    logic                 w_first;
    logic                 w_force;
    logic                 w_end;
    logic                 w_sgn;
    logic [c_cnt_w-1:0]   r_beat_cnt;
    logic                 r_sgn;

    // A pending result that the consumer has not taken freezes every stage.
    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !rst && !w_stall;
    assign w_accept = in_valid && in_ready;

    // r_beat_cnt is the index of the next beat within the vector; zero means
    // the next accepted beat opens a new vector.
    assign w_first = (r_beat_cnt == '0);
    assign w_force = (r_beat_cnt == c_cnt_w'(MAX_BEATS - 1)) && !in_last;
    assign w_end   = in_last || w_force;
    assign w_sgn   = w_first ? in_signed : r_sgn;

    // ------------------------------------------------------------------
    // Per-lane products (operands extended to product width, so the
    // truncated product is exact in both signed and unsigned modes)
    // ------------------------------------------------------------------
    logic [N_LANES*c_prod_w-1:0] w_prod;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        logic [c_prod_w-1:0] w_a;
        logic [c_prod_w-1:0] w_c;
        assign w_a = {{(c_prod_w-DW){w_sgn & a_in[i*DW+DW-1]}}, a_in[i*DW +: DW]};
        assign w_c = {{(c_prod_w-DW){w_sgn & c_in[i*DW+DW-1]}}, c_in[i*DW +: DW]};
        assign w_prod[i*c_prod_w +: c_prod_w] = w_a * w_c;
    end

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic [N_LANES*c_prod_w-1:0] r_s1_prod;
    logic                        r_s1_valid, r_s1_first, r_s1_last, r_s1_err, r_s1_sgn;
    logic                        r_s2_valid, r_s2_first, r_s2_last, r_s2_err, r_s2_sgn;
    logic signed [c_sum_w-1:0]   w_s2_sum;
    logic signed [c_acc_w-1:0]   r_acc;

    mac_add_tree #(
        .N_LANES (N_LANES),
        .IN_W    (c_prod_w),
        .SUM_W   (c_sum_w)
    ) u_add_tree (
        .clk     (clk),
        .rst     (rst),
        .en      (!w_stall),
        .in_data (r_s1_prod),
        .sum_out (w_s2_sum)
    );

    // ------------------------------------------------------------------
    // S3 accumulate and clamp
    // ------------------------------------------------------------------
    logic signed [c_acc_w-1:0] w_sum_ext;
    logic signed [c_acc_w-1:0] w_total;
    logic [OUT_W-1:0]          w_clamped;
    logic                      w_sat;

    assign w_sum_ext = c_acc_w'(w_s2_sum);
    assign w_total   = r_s2_first ? w_sum_ext : r_acc + w_sum_ext;

    always_comb begin
        w_clamped = w_total[OUT_W-1:0];
        w_sat     = 1'b0;
        if (r_s2_sgn) begin
            if (w_total > c_smax) begin
                w_clamped = c_smax[OUT_W-1:0];
                w_sat     = 1'b1;
            end else if (w_total < c_smin) begin
                w_clamped = c_smin[OUT_W-1:0];
                w_sat     = 1'b1;
            end
        end else if (w_total > c_umax) begin
            w_clamped = c_umax[OUT_W-1:0];
            w_sat     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_sgn      <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_sgn   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_err   <= 1'b0;
            r_s2_sgn   <= 1'b0;
            r_acc      <= '0;
            out_data   <= '0;
            out_sat    <= 1'b0;
            out_err    <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sgn      <= w_sgn;
                r_beat_cnt <= w_end ? '0 : r_beat_cnt + 1'b1;
            end
            if (!w_stall) begin
                r_s1_valid <= w_accept;
                r_s1_prod  <= w_prod;
                r_s1_first <= w_first;
                r_s1_last  <= w_end;
                r_s1_err   <= w_force;
                r_s1_sgn   <= w_sgn;

                r_s2_valid <= r_s1_valid;
                r_s2_first <= r_s1_first;
                r_s2_last  <= r_s1_last;
                r_s2_err   <= r_s1_err;
                r_s2_sgn   <= r_s1_sgn;

                // Not stalled implies any held result is being taken now, so
                // out_valid simply follows whether a new result completes.
                out_valid <= r_s2_valid && r_s2_last;
                if (r_s2_valid) begin
                    r_acc <= w_total;
                    if (r_s2_last) begin
                        out_data <= w_clamped;
                        out_sat  <= w_sat;
                        out_err  <= r_s2_err;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_vec_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_vec_pipe
//  Description : Scoreboard bench for mac_vec_pipe with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_vec_pipe;

    localparam int N  = 5;
    localparam int DW = 8;
    localparam int OW = 16;
    localparam int MB = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*DW-1:0]   a_in = '0;
    logic [N*DW-1:0]   c_in = '0;
    logic              in_signed = 1'b0;
    logic              in_last = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [OW-1:0]     out_data;
    logic              out_sat;
    logic              out_err;
    logic              out_valid;
    logic              out_ready = 1'b1;

    mac_vec_pipe #(
        .N_LANES   (N),
        .DW        (DW),
        .OUT_W     (OW),
        .MAX_BEATS (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .c_in      (c_in),
        .in_signed (in_signed),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          sat;
        logic          err;
    } res_t;

    res_t   exp_q[$];
    res_t   mon_e;
    int     n_checks = 0;
    int     n_fail   = 0;
    longint m_acc    = 0;
    int     m_beats  = 0;
    logic   m_sgn    = 1'b0;
    int     last_acc_cyc = 0;
    logic   rnd_done = 1'b0;
    logic   snd_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] v);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [N*DW-1:0] rnd_vec();
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    // Reference model: exact integer dot product, clamped at vector end.
    task automatic model_beat(input logic [N*DW-1:0] a, input logic [N*DW-1:0] c,
                              input logic sgn, input logic last);
        longint av, cv, lo, hi, v;
        res_t   r;
        if (m_beats == 0) m_sgn = sgn;
        for (int i = 0; i < N; i++) begin
            av = m_sgn ? longint'($signed(a[i*DW +: DW])) : longint'(a[i*DW +: DW]);
            cv = m_sgn ? longint'($signed(c[i*DW +: DW])) : longint'(c[i*DW +: DW]);
            m_acc += av * cv;
        end
        m_beats++;
        if (last || m_beats == MB) begin
            if (m_sgn) begin
                lo = -(longint'(1) <<< (OW - 1));
                hi = (longint'(1) <<< (OW - 1)) - 1;
            end else begin
                lo = 0;
                hi = (longint'(1) <<< OW) - 1;
            end
            v     = (m_acc > hi) ? hi : (m_acc < lo) ? lo : m_acc;
            r.data = OW'(v);
            r.sat  = (v != m_acc);
            r.err  = (m_beats == MB) && !last;
            exp_q.push_back(r);
            m_acc   = 0;
            m_beats = 0;
        end
    endtask

    // Called at a falling edge; returns at a falling edge after acceptance.
    task automatic send_beat(input logic [N*DW-1:0] a, input logic [N*DW-1:0] c,
                             input logic sgn, input logic last);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        a_in = a; c_in = c; in_signed = sgn; in_last = last; in_valid = 1'b1;
        while (!acc) begin
            #1;
            acc = in_ready;
            last_acc_cyc = cyc;
            @(negedge clk);
            if (!acc) begin
                tries++;
                if (tries > 300) begin
                    check("accept_timeout", 32'd0, 32'd1);
                    break;
                end
            end
        end
        in_valid = 1'b0;
        if (acc) model_beat(a, c, sgn, last);
    endtask

    // Scoreboard: a result is consumed on the edge where valid && ready.
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {16'd0, out_data}, 32'hDEAD);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", {16'd0, out_data}, {16'd0, mon_e.data});
                check("out_sat",  {31'd0, out_sat},  {31'd0, mon_e.sat});
                check("out_err",  {31'd0, out_err},  {31'd0, mon_e.err});
            end
        end
    end

    initial begin
        int w;
        logic [OW-1:0] held;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_out_data",  {16'd0, out_data},  32'd0);
        check("post_rst_out_sat",   {31'd0, out_sat},   32'd0);
        check("post_rst_out_err",   {31'd0, out_err},   32'd0);
        @(negedge clk);

        // Single beat 10*3 per lane -> 150, latency 3 cycles
        send_beat(fill(8'd10), fill(8'd3), 1'b0, 1'b1);
        w = 0;
        while (!out_valid && w < 20) begin @(negedge clk); w++; end
        check("latency", cyc - last_acc_cyc, 32'd3);
        repeat (3) @(negedge clk);

        // Unsigned saturation
        send_beat(fill(8'd255), fill(8'd255), 1'b0, 1'b1);
        // Signed two-beat vector -> -45
        send_beat(fill(8'hFE), fill(8'd7), 1'b1, 1'b0);
        send_beat(fill(8'd1),  fill(8'd5), 1'b1, 1'b1);
        // Sign mode changes mid-vector must be ignored
        send_beat(fill(8'hFD), fill(8'd4), 1'b1, 1'b0);
        send_beat(fill(8'hFF), fill(8'd2), 1'b0, 1'b1);
        // Negative signed saturation
        send_beat(fill(8'h80), fill(8'd127), 1'b1, 1'b0);
        send_beat(fill(8'h80), fill(8'd127), 1'b1, 1'b1);
        repeat (5) @(negedge clk);

        // Backpressure: hold out_ready low with a result pending
        out_ready = 1'b0;
        snd_done  = 1'b0;
        fork
            begin
                send_beat(fill(8'd2), fill(8'd2), 1'b0, 1'b1);
                send_beat(fill(8'd1), fill(8'd9), 1'b0, 1'b0);
                send_beat(fill(8'd3), fill(8'd1), 1'b0, 1'b1);
                snd_done = 1'b1;
            end
        join_none
        w = 0;
        while (!out_valid && w < 30) begin @(negedge clk); w++; end
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        held = out_data;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_hold", {16'd0, out_data}, {16'd0, held});
        end
        @(negedge clk);
        out_ready = 1'b1;
        w = 0;
        while (!snd_done && w < 300) begin @(negedge clk); w++; end
        check("stall_sender_done", {31'd0, snd_done}, 32'd1);
        repeat (6) @(negedge clk);

        // 16 beats without in_last -> forced end, 80, err
        for (int b = 0; b < MB; b++) send_beat(fill(8'd1), fill(8'd1), 1'b0, 1'b0);
        repeat (6) @(negedge clk);

        // Reset mid-vector discards the partial vector
        send_beat(fill(8'd2), fill(8'd3), 1'b0, 1'b0);
        send_beat(fill(8'd2), fill(8'd3), 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        m_acc   = 0;
        m_beats = 0;
        #1;
        check("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        send_beat(fill(8'd1), fill(8'd1), 1'b0, 1'b1);
        repeat (6) @(negedge clk);

        // Random vectors with random backpressure
        fork
            begin
                while (!rnd_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join_none
        for (int v = 0; v < 20; v++) begin
            int   nb;
            logic sg;
            nb = $urandom_range(1, 3);
            sg = 1'($urandom_range(0, 1));
            for (int b = 0; b < nb; b++) send_beat(rnd_vec(), rnd_vec(), sg, b == nb - 1);
        end
        rnd_done = 1'b1;
        repeat (2) @(negedge clk);

        // Drain
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin @(negedge clk); w++; end
        check("drain", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
